// File: rtl/regblock_pipe.sv
// rtl/regblock_pipe.sv - register file with forwarding and a two-stage valid/ready ALU pipeline
module regblock_pipe #(
  parameter int RWIDTH   = 6,
  parameter int DWIDTH   = 32,
  parameter int IMM_IN   = 15,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RWIDTH-1:0] rs,
  input  logic [RWIDTH-1:0] rt,
  input  logic [RWIDTH-1:0] rd,
  input  logic              wb_en,
  input  logic              muxsel1,
  input  logic              imm_sext,
  input  logic [IMM_IN-1:0] imm_in,
  input  logic [3:0]        ALUopsel,
  input  logic              we,
  input  logic [RWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] wd,
  output logic [DWIDTH-1:0] opBwd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] ALUresult,
  output logic [RWIDTH-1:0] out_rd,
  output logic              zero,
  output logic              ovf
);

  localparam int NREG = 1 << RWIDTH;
  localparam int SHW  = $clog2(DWIDTH);
  localparam int MSB  = DWIDTH - 1;

  logic [DWIDTH-1:0] regs [NREG];

  logic              s1_valid;
  logic [DWIDTH-1:0] s1_a;
  logic [DWIDTH-1:0] s1_b;
  logic [3:0]        s1_op;
  logic [RWIDTH-1:0] s1_rd;
  logic              s1_wb;
  logic              out_wb;

  logic [DWIDTH-1:0] alu_res;
  logic              alu_ovf;
  logic [DWIDTH-1:0] imm_ext;
  logic [DWIDTH-1:0] op_a;
  logic [DWIDTH-1:0] op_b;
  logic              s1_adv;
  logic              issue;
  logic              wb_wr;
  logic              ext_wr;

  function automatic logic is_zero_reg(input logic [RWIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Youngest producer wins: S1 result, then S2 result, then same-cycle external write, then storage.
  function automatic logic [DWIDTH-1:0] fwd(input logic [RWIDTH-1:0] a);
    if (is_zero_reg(a)) return '0;
    if (s1_valid && s1_wb && s1_rd == a) return alu_res;
    if (out_valid && out_wb && out_rd == a) return ALUresult;
    if (we && wa == a) return wd;
    return regs[a];
  endfunction

  assign imm_ext = {{(DWIDTH-IMM_IN){imm_sext & imm_in[IMM_IN-1]}}, imm_in};
  assign op_a    = fwd(rs);
  assign opBwd   = fwd(rt);
  assign op_b    = muxsel1 ? imm_ext : opBwd;

  assign s1_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s1_adv;
  assign issue    = in_valid & in_ready;
  assign zero     = (ALUresult == '0);

  // Retire writeback takes precedence over an external write to the same register.
  assign wb_wr  = out_valid & out_ready & out_wb & ~is_zero_reg(out_rd);
  assign ext_wr = we & ~is_zero_reg(wa) & ~(wb_wr && wa == out_rd);

  // ALU on the S1 operands; overflow only meaningful for ADD/SUB.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (s1_op)
      4'd0: begin
        alu_res = s1_a + s1_b;
        alu_ovf = (s1_a[MSB] == s1_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
      end
      4'd1: begin
        alu_res = s1_a - s1_b;
        alu_ovf = (s1_a[MSB] != s1_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
      end
      4'd2:  alu_res = s1_a & s1_b;
      4'd3:  alu_res = s1_a | s1_b;
      4'd4:  alu_res = s1_a ^ s1_b;
      4'd5:  alu_res = ~(s1_a | s1_b);
      4'd6:  alu_res = s1_a << s1_b[SHW-1:0];
      4'd7:  alu_res = s1_a >> s1_b[SHW-1:0];
      4'd8:  alu_res = $signed(s1_a) >>> s1_b[SHW-1:0];
      4'd9:  alu_res = {{(DWIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      4'd10: alu_res = {{(DWIDTH-1){1'b0}}, (s1_a < s1_b)};
      4'd11: alu_res = s1_b;
      default: ;
    endcase
  end

  // Register file: external writes and retire writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (ext_wr) regs[wa] <= wd;
      if (wb_wr) regs[out_rd] <= ALUresult;
    end
  end

  // Stage S1: capture forwarded operands on issue, empty when advancing without a new issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_wb    <= 1'b0;
    end else if (issue) begin
      s1_valid <= 1'b1;
      s1_a     <= op_a;
      s1_b     <= op_b;
      s1_op    <= ALUopsel;
      s1_rd    <= rd;
      s1_wb    <= wb_en;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage S2: result register, held stable while stalled by the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALUresult <= '0;
      out_rd    <= '0;
      out_wb    <= 1'b0;
      ovf       <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      ALUresult <= alu_res;
      out_rd    <= s1_rd;
      out_wb    <= s1_wb;
      ovf       <= alu_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regblock_pipe.sv
// tb/tb_regblock_pipe.sv - directed self-checking bench for regblock_pipe
module tb_regblock_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  rs, rt, rd;
  logic        wb_en, muxsel1, imm_sext;
  logic [14:0] imm_in;
  logic [3:0]  ALUopsel;
  logic        we;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic [31:0] opBwd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUresult;
  logic [5:0]  out_rd;
  logic        zero, ovf;

  regblock_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .rd(rd), .wb_en(wb_en), .muxsel1(muxsel1),
    .imm_sext(imm_sext), .imm_in(imm_in), .ALUopsel(ALUopsel),
    .we(we), .wa(wa), .wd(wd), .opBwd(opBwd),
    .out_valid(out_valid), .out_ready(out_ready), .ALUresult(ALUresult),
    .out_rd(out_rd), .zero(zero), .ovf(ovf)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        v;
  } alu_vec_t;

  typedef struct {
    logic [5:0]  rd;
    logic [31:0] res;
    logic        z;
  } ret_t;

  alu_vec_t vecs[16];
  ret_t     retq[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  logic [31:0] rv;
  logic [31:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every retiring result, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) retq.push_back('{out_rd, ALUresult, zero});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [5:0] a, input logic [5:0] b, input logic [5:0] d,
                          input logic wb, input logic msel, input logic sext,
                          input logic [14:0] imm, input logic [3:0] op);
    rs = a; rt = b; rd = d; wb_en = wb; muxsel1 = msel; imm_sext = sext;
    imm_in = imm; ALUopsel = op; in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    if (!in_ready) check("issue_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    if (!out_valid) check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic wait_retq(input int n);
    for (int i = 0; i < 50 && retq.size() < n; i++) tick();
    if (retq.size() < n) check("retire_timeout", retq.size(), n);
    tick();
  endtask

  task automatic read_reg(input logic [5:0] a, output logic [31:0] v);
    rt = a;
    #1;
    v = opBwd;
  endtask

  task automatic ext_write(input logic [5:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[2]  = '{4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[3]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vecs[4]  = '{4'd3,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0};
    vecs[5]  = '{4'd4,  32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0, 1'b0, 1'b0};
    vecs[6]  = '{4'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[7]  = '{4'd6,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0};
    vecs[8]  = '{4'd6,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0};
    vecs[9]  = '{4'd7,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0};
    vecs[10] = '{4'd8,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[11] = '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[12] = '{4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{4'd11, 32'h00000000, 32'h0000ABCD, 32'h0000ABCD, 1'b0, 1'b0};
    vecs[14] = '{4'd13, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[15] = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; rs = '0; rt = '0; rd = '0; wb_en = 1'b0;
    muxsel1 = 1'b0; imm_sext = 1'b0; imm_in = '0; ALUopsel = '0;
    we = 1'b0; wa = '0; wd = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", ALUresult, 32'd0);
    check("rst_out_rd", {26'b0, out_rd}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd1);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: external write forwarded into a same-cycle issue, zero-extended immediate
    we = 1'b1; wa = 6'd63; wd = 32'hFFAAFFAA;
    issue_op(6'd63, 6'd0, 6'd5, 1'b1, 1'b1, 1'b0, 15'h1FFF, 4'd0);
    we = 1'b0;
    check("t1_latency_s1", {31'b0, out_valid}, 32'd0);
    tick();
    check("t1_out_valid", {31'b0, out_valid}, 32'd1);
    check("t1_result", ALUresult, 32'hFFAB1FA9);
    check("t1_out_rd", {26'b0, out_rd}, 32'd5);
    tick();
    read_reg(6'd5, rv);
    check("t1_reg5", rv, 32'hFFAB1FA9);
    read_reg(6'd63, rv);
    check("t1_reg63", rv, 32'hFFAAFFAA);
    retq.delete();

    // 2: back-to-back dependencies through S1 forwarding
    issue_op(6'd0, 6'd0, 6'd1, 1'b1, 1'b1, 1'b0, 15'd7, 4'd0);
    issue_op(6'd1, 6'd0, 6'd2, 1'b1, 1'b1, 1'b0, 15'd3, 4'd0);
    issue_op(6'd2, 6'd2, 6'd7, 1'b1, 1'b0, 1'b0, 15'd0, 4'd1);
    wait_retq(3);
    if (retq.size() >= 3) begin
      check("t2_res0", retq[0].res, 32'd7);
      check("t2_res1", retq[1].res, 32'h0000000A);
      check("t2_res2", retq[2].res, 32'd0);
      check("t2_zero2", {31'b0, retq[2].z}, 32'd1);
    end
    read_reg(6'd2, rv);
    check("t2_reg2", rv, 32'h0000000A);
    retq.delete();

    // 3: backpressure for five cycles with three ops offered
    out_ready = 1'b0;
    rs = 6'd0; rt = 6'd0; wb_en = 1'b1; muxsel1 = 1'b1; imm_sext = 1'b0; ALUopsel = 4'd0;
    rd = 6'd20; imm_in = 15'd100; in_valid = 1'b1;
    #1 check("t3_ready_a", {31'b0, in_ready}, 32'd1);
    tick();
    rd = 6'd21; imm_in = 15'd200;
    check("t3_ready_b", {31'b0, in_ready}, 32'd1);
    tick();
    rd = 6'd22; imm_in = 15'd300;
    check("t3_ready_c", {31'b0, in_ready}, 32'd0);
    check("t3_hold_res", ALUresult, 32'd100);
    check("t3_hold_rd", {26'b0, out_rd}, 32'd20);
    held = ALUresult;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_stall_ready", {31'b0, in_ready}, 32'd0);
      check("t3_stall_hold", ALUresult, held);
      check("t3_no_retire", retq.size(), 32'd0);
    end
    out_ready = 1'b1;
    #1 check("t3_ready_release", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    wait_retq(3);
    if (retq.size() >= 3) begin
      check("t3_rd0", {26'b0, retq[0].rd}, 32'd20);
      check("t3_rd1", {26'b0, retq[1].rd}, 32'd21);
      check("t3_rd2", {26'b0, retq[2].rd}, 32'd22);
      check("t3_res2", retq[2].res, 32'd300);
    end
    read_reg(6'd21, rv);
    check("t3_reg21", rv, 32'd200);
    read_reg(6'd22, rv);
    check("t3_reg22", rv, 32'd300);
    retq.delete();

    // 4: writeback versus external write collisions
    ext_write(6'd12, 32'h12345678);
    out_ready = 1'b0;
    issue_op(6'd0, 6'd12, 6'd3, 1'b1, 1'b0, 1'b0, 15'd0, 4'd11);
    tick();
    check("t4_pending", ALUresult, 32'h12345678);
    we = 1'b1; wa = 6'd3; wd = 32'h0000DEAD; out_ready = 1'b1;
    tick();
    we = 1'b0;
    read_reg(6'd3, rv);
    check("t4_same_addr", rv, 32'h12345678);
    ext_write(6'd3, 32'd0);
    out_ready = 1'b0;
    issue_op(6'd0, 6'd12, 6'd3, 1'b1, 1'b0, 1'b0, 15'd0, 4'd11);
    tick();
    we = 1'b1; wa = 6'd4; wd = 32'h0000DEAD; out_ready = 1'b1;
    tick();
    we = 1'b0;
    read_reg(6'd3, rv);
    check("t4_diff_wb", rv, 32'h12345678);
    read_reg(6'd4, rv);
    check("t4_diff_ext", rv, 32'h0000DEAD);
    retq.delete();

    // 5: ALU operation table
    for (int k = 0; k < 16; k++) begin
      ext_write(6'd10, vecs[k].a);
      ext_write(6'd11, vecs[k].b);
      issue_op(6'd10, 6'd11, 6'd0, 1'b0, 1'b0, 1'b0, 15'd0, vecs[k].op);
      wait_out_valid();
      check($sformatf("t5_res_%0d", k), ALUresult, vecs[k].res);
      check($sformatf("t5_zero_%0d", k), {31'b0, zero}, {31'b0, vecs[k].z});
      check($sformatf("t5_ovf_%0d", k), {31'b0, ovf}, {31'b0, vecs[k].v});
    end
    issue_op(6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 15'h4000, 4'd0);
    wait_out_valid();
    check("t5_imm_sext", ALUresult, 32'hFFFFC000);
    ext_write(6'd0, 32'd5);
    read_reg(6'd0, rv);
    check("t5_reg0", rv, 32'd0);
    tick();
    retq.delete();

    // 6: reset with two write-back ops in flight
    issue_op(6'd0, 6'd0, 6'd30, 1'b1, 1'b1, 1'b0, 15'd9, 4'd0);
    issue_op(6'd0, 6'd0, 6'd31, 1'b1, 1'b1, 1'b0, 15'd10, 4'd0);
    rst = 1'b1;
    #1;
    check("t6_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    read_reg(6'd30, rv);
    check("t6_reg30", rv, 32'd0);
    read_reg(6'd31, rv);
    check("t6_reg31", rv, 32'd0);
    read_reg(6'd5, rv);
    check("t6_reg5_cleared", rv, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regblock_pipe.md
Name: regblock_pipe

Overview:
- Parametrised successor to the single-cycle register block.
- Combines a 2^RWIDTH x DWIDTH register file (two read ports, one external write port) with an operand-B mux (rt or extended immediate) and a two-stage valid/ready pipelined ALU.
- Adds automatic result writeback, full operand forwarding and backpressure.
- Sits between the controller/decoder and downstream memory/branch logic.

Parameters:
- RWIDTH, 6, register address width; 2^RWIDTH registers.
- DWIDTH, 32, data width; must be a power of two, >= 8.
- IMM_IN, 15, immediate width; must be < DWIDTH.
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  issue request
- in_ready  out  1  issue accepted when in_valid & in_ready
- rs  in  RWIDTH  operand-A register
- rt  in  RWIDTH  operand-B register
- rd  in  RWIDTH  destination register for writeback
- wb_en  in  1  write result to rd on retire
- muxsel1  in  1  1: opB = extended imm_in; 0: opB = reg[rt]
- imm_sext  in  1  1: sign-extend imm_in; 0: zero-extend
- imm_in  in  IMM_IN  immediate
- ALUopsel  in  4  operation select
- we  in  1  external write enable
- wa  in  RWIDTH  external write address
- wd  in  DWIDTH  external write data
- opBwd  out  DWIDTH  forwarded reg[rt] value at issue (store data), combinational
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- ALUresult  out  DWIDTH  registered result
- out_rd  out  RWIDTH  destination tag of result
- zero  out  1  ALUresult == 0
- ovf  out  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Reset (async):
  - All registers cleared.
  - in_ready=1, out_valid=0, ALUresult=0, out_rd=0, zero=1, ovf=0.
  - Both stage valids are cleared.
  - Reset mid-operation discards all in-flight ops, and no writeback occurs.
- Stage S1 (operand): on issue, captures the forwarded opA, opB, ALUopsel, rd and wb_en.
- Stage S2 (result):
  - Captures the ALU output computed from S1.
  - S1 advances when s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | S1 advancing.
  - Latency: an op issued at edge N presents out_valid after edge N+1.
  - Throughput is 1 op/cycle with out_ready held high.
- Hold: while out_valid & !out_ready, ALUresult, out_rd, zero and ovf hold stable.
- Retire: occurs at out_valid & out_ready. If wb_en was set, reg[out_rd] <= ALUresult at that edge.
- Write collision: if the external write and the retire writeback target the same register in the same edge, writeback wins and the external write is dropped. Different addresses both write.
- Forwarding for each of rs and rt at issue, highest priority first:
  - S1 op with wb_en and matching rd: combinational ALU output.
  - S2 op with wb_en and matching out_rd: ALUresult.
  - External we with matching wa: wd.
  - Register file.
- Register 0 with ZERO_REG=1 always reads 0 and is never forwarded.
- Immediate: extended to DWIDTH per imm_sext before the mux.
- ALUopsel encoding (results truncated to DWIDTH; shift amount = opB[log2(DWIDTH)-1:0]):
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOR
  - 6 SLL
  - 7 SRL
  - 8 SRA
  - 9 SLT (signed, result 0/1)
  - 10 SLTU
  - 11 PASSB
  - 12-15: result 0, ovf 0
- ovf: set when operand signs imply signed overflow for ADD/SUB.
- External write (we) is independent of the pipeline and is accepted every cycle.

Test Plan:
1. Reset, then we=1, wa=63, wd=FFAAFFAA. Issue rs=63, muxsel1=1, imm_in=0x1FFF, imm_sext=0, ADD, rd=5, wb_en=1 -> out_valid two edges after issue, ALUresult=FFAB1FA9. After retire, reg5=FFAB1FA9.
2. Back-to-back dependency: issue rs=0, imm=7, ADD, rd=1; then next cycle issue rs=1, imm=3, ADD, rd=2 -> second result=0x0000000A via S1 forwarding. Then rs=2, rt=2, SUB -> 0, zero=1.
3. Backpressure: out_ready=0 for 5 cycles with 3 ops issued -> in_ready drops after 2 accepted ops. ALUresult holds stable. No writeback occurs until out_ready=1. Results then retire in order.
4. Collision: retire writeback of 0x12345678 to reg3 while we=1, wa=3, wd=0xDEAD -> reg3=0x12345678. The same scenario with wa=4 -> reg4=0xDEAD.
5. ALU edges:
   - ADD 7FFFFFFF+1 -> 80000000, ovf=1.
   - SRA 80000000 by 31 -> FFFFFFFF.
   - SLT FFFFFFFF,1 -> 1.
   - SLTU -> 0.
   - Op 13 -> 0.
   - Register 0 written with wd=5 -> reads 0.
6. Assert rst while 2 ops are in flight with wb_en -> out_valid=0 immediately, destination registers stay 0, in_ready=1.
